schmidl_cox_peak_detector: RTL and testbench

- Sits directly downstream of the Schmidl-Cox metric calculator and consumes its normalized M(d) stream (unsigned 32-bit quotient per sample).
- On a threshold crossing, it searches a fixed window for the metric maximum and emits one detection record per frame: the sample index of the peak.
- After a report it applies a hold-off so that the plateau and sidelobes of the same preamble do not re-trigger it.
- The output feeds the frame-timing / CFO-correction control logic.

---
 rtl/schmidl_cox_peak_detector_pkg.sv | 9 +
 rtl/schmidl_cox_peak_detector_if.sv | 9 +
 rtl/schmidl_cox_peak_detector_running_argmax.sv | 34 +++
 rtl/schmidl_cox_peak_detector.sv | 108 ++++++++++
 tb/tb_schmidl_cox_peak_detector.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/schmidl_cox_peak_detector_pkg.sv
// schmidl_cox_pkg: shared FSM states, FFT-derived default lengths and counter sizing for the peak detector.
package schmidl_cox_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, REPORT, HOLDOFF} state_t;
    localparam int FFT_SIZE = 1024;
    localparam int HALF_FFT_SIZE = FFT_SIZE / 2;
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/schmidl_cox_peak_detector_if.sv
// schmidl_cox_peak_detector_if: valid/ready stream with tlast, used for the metric input and detection output.
interface schmidl_cox_peak_detector_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] tdata;
    logic tlast;
    logic tvalid;
    logic tready;
    modport master(output tdata, tlast, tvalid, input tready);
    modport slave(input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/schmidl_cox_peak_detector_running_argmax.sv
// running_argmax: best value/index register; load starts a search, update keeps the earliest strict maximum.
// best_val becomes a port only when SCHMIDL_COX_PEAK_VALUE_EN is defined.
module running_argmax #(
    parameter int VAL_WIDTH = 32,
    parameter int IDX_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 load,
    input  logic                 update,
    input  logic [VAL_WIDTH-1:0] val,
    input  logic [IDX_WIDTH-1:0] idx,
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
    output logic [VAL_WIDTH-1:0] best_val,
`endif
    output logic [IDX_WIDTH-1:0] best_idx
);
`ifndef SCHMIDL_COX_PEAK_VALUE_EN
    logic [VAL_WIDTH-1:0] best_val;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (clear) begin
            best_val <= '0;
            best_idx <= '0;
        end else if (load || (update && val > best_val)) begin
            best_val <= val;
            best_idx <= idx;
        end
    end
endmodule

// File: rtl/schmidl_cox_peak_detector.sv
// schmidl_cox_peak_detector: threshold-triggered windowed argmax over the Schmidl-Cox metric with post-report hold-off.
// Define SCHMIDL_COX_PEAK_VALUE_EN to add the o_tpeak output carrying the peak metric value.
module schmidl_cox_peak_detector
    import schmidl_cox_pkg::*;
#(
    parameter int METRIC_WIDTH = 32,
    parameter int INDEX_WIDTH  = 32,
    parameter int WINDOW_LEN   = HALF_FFT_SIZE,
    parameter int HOLDOFF_LEN  = FFT_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [METRIC_WIDTH-1:0] threshold,
    schmidl_cox_peak_detector_if.slave  metric,
    schmidl_cox_peak_detector_if.master detect
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
    ,
    output logic [METRIC_WIDTH-1:0] o_tpeak
`endif
);
    localparam int WW = cnt_width(WINDOW_LEN);
    localparam int HW = cnt_width(HOLDOFF_LEN);
    localparam logic [WW-1:0] WIN_END  = WW'(WINDOW_LEN - 1);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLDOFF_LEN - 1);

    state_t state;
    logic [INDEX_WIDTH-1:0] index;
    logic [WW-1:0] win_cnt;
    logic [HW-1:0] hold_cnt;
    logic beat;
    logic hit;

    assign metric.tready = state != REPORT;
    assign beat = metric.tvalid && metric.tready;
    assign hit = metric.tdata >= threshold;

    running_argmax #(.VAL_WIDTH(METRIC_WIDTH), .IDX_WIDTH(INDEX_WIDTH)) argmax (
        .clk(clk),
        .rst(reset),
        .clear(clear),
        .load(beat && state == IDLE && hit),
        .update(beat && state == SEARCH),
        .val(metric.tdata),
        .idx(index),
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
        .best_val(o_tpeak),
`endif
        .best_idx(detect.tdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            win_cnt <= '0;
            hold_cnt <= '0;
            detect.tvalid <= 1'b0;
            detect.tlast <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            index <= '0;
            win_cnt <= '0;
            hold_cnt <= '0;
            detect.tvalid <= 1'b0;
            detect.tlast <= 1'b0;
        end else begin
            if (beat)
                index <= index + 1'b1;
            case (state)
                IDLE:
                    if (beat && hit) begin
                        win_cnt <= WW'(1);
                        if (WINDOW_LEN == 1 || metric.tlast) begin
                            state <= REPORT;
                            detect.tvalid <= 1'b1;
                            detect.tlast <= metric.tlast;
                        end else
                            state <= SEARCH;
                    end
                SEARCH:
                    if (beat) begin
                        win_cnt <= win_cnt + 1'b1;
                        if (metric.tlast || win_cnt == WIN_END) begin
                            state <= REPORT;
                            detect.tvalid <= 1'b1;
                            detect.tlast <= metric.tlast;
                        end
                    end
                // a burst cut short by tlast starts the next burst armed, without hold-off
                REPORT:
                    if (detect.tready) begin
                        detect.tvalid <= 1'b0;
                        detect.tlast <= 1'b0;
                        hold_cnt <= '0;
                        state <= (HOLDOFF_LEN == 0 || detect.tlast) ? IDLE : HOLDOFF;
                    end
                HOLDOFF:
                    if (beat) begin
                        hold_cnt <= hold_cnt + 1'b1;
                        if (metric.tlast || hold_cnt == HOLD_END)
                            state <= IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_schmidl_cox_peak_detector.sv
// tb_schmidl_cox_peak_detector: directed test-plan scenarios plus random bursts scored against an offline window/hold-off model.
module tb_schmidl_cox_peak_detector;
    localparam int W = 4;
    localparam int H = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic [31:0] threshold = 32'd100;
    schmidl_cox_peak_detector_if #(.WIDTH(32)) metric ();
    schmidl_cox_peak_detector_if #(.WIDTH(32)) detect ();
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
    logic [31:0] o_tpeak;
`endif

    schmidl_cox_peak_detector #(.WINDOW_LEN(W), .HOLDOFF_LEN(H)) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .threshold(threshold),
        .metric(metric),
        .detect(detect)
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
        ,
        .o_tpeak(o_tpeak)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] beat_val[$];
    logic beat_last[$];
    logic [31:0] got_idx[$], got_peak[$];
    logic got_last[$];
    logic [31:0] exp_idx[$], exp_peak[$];
    logic exp_last[$];
    logic stalled = 1'b0;
    logic [31:0] held_idx = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // accepted beats and released records are logged half a cycle before the edge that takes them
    always @(negedge clk) begin
        if (reset || clear)
            stalled = 1'b0;
        else begin
            if (stalled)
                check("stall_hold", detect.tdata, held_idx);
            if (detect.tvalid)
                check("ready_in_report", metric.tready, 0);
            if (metric.tvalid && metric.tready) begin
                beat_val.push_back(metric.tdata);
                beat_last.push_back(metric.tlast);
            end
            if (detect.tvalid && detect.tready) begin
                got_idx.push_back(detect.tdata);
                got_last.push_back(detect.tlast);
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
                got_peak.push_back(o_tpeak);
`else
                got_peak.push_back(32'd0);
`endif
            end
            stalled = detect.tvalid && !detect.tready;
            held_idx = detect.tdata;
        end
    end

    task automatic flush_logs();
        beat_val.delete();
        beat_last.delete();
        got_idx.delete();
        got_last.delete();
        got_peak.delete();
        exp_idx.delete();
        exp_last.delete();
        exp_peak.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        metric.tvalid = 1'b0;
        metric.tlast = 1'b0;
        metric.tdata = '0;
        detect.tready = 1'b1;
        flush_logs();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        check("reset_tvalid", detect.tvalid, 0);
        check("reset_tready", metric.tready, 1);
    endtask

    task automatic send(input logic [31:0] v, input logic l);
        int t = 0;
        metric.tdata = v;
        metric.tlast = l;
        metric.tvalid = 1'b1;
        @(negedge clk);
        while (!metric.tready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100)
            check("send_timeout", 1, 0);
        @(posedge clk);
        #1 metric.tvalid = 1'b0;
    endtask

    task automatic expect_rec(input logic [31:0] idx, input logic last, input logic [31:0] peak);
        exp_idx.push_back(idx);
        exp_last.push_back(last);
        exp_peak.push_back(peak);
    endtask

    task automatic compare_recs(input string tag);
        check({tag, "_count"}, got_idx.size(), exp_idx.size());
        for (int k = 0; k < exp_idx.size() && k < got_idx.size(); k++) begin
            check({tag, "_idx"}, got_idx[k], exp_idx[k]);
            check({tag, "_last"}, got_last[k], exp_last[k]);
`ifdef SCHMIDL_COX_PEAK_VALUE_EN
            check({tag, "_peak"}, got_peak[k], exp_peak[k]);
`endif
        end
    endtask

    // offline scan of the whole accepted stream: find crossings, take the earliest max of each window, then skip the hold-off
    task automatic build_expected(input logic [31:0] thr);
        int i, n, e, b, k;
        bit done, t;
        exp_idx.delete();
        exp_last.delete();
        exp_peak.delete();
        n = beat_val.size();
        i = 0;
        while (i < n) begin
            if (beat_val[i] < thr) begin
                i++;
                continue;
            end
            e = i;
            done = 0;
            while (!done && e < n) begin
                if (beat_last[e] || e - i + 1 == W)
                    done = 1;
                else
                    e++;
            end
            if (!done)
                break;
            b = i;
            for (int j = i + 1; j <= e; j++)
                if (beat_val[j] > beat_val[b])
                    b = j;
            expect_rec(32'(b), beat_last[e], beat_val[b]);
            i = e + 1;
            if (!beat_last[e])
                for (k = 0; k < H && i < n; k++) begin
                    t = beat_last[i];
                    i++;
                    if (t)
                        break;
                end
        end
    endtask

    task automatic random_run(input int cycles, input logic [31:0] thr);
        threshold = thr;
        repeat (cycles) begin
            metric.tvalid = $urandom_range(0, 3) != 0;
            metric.tdata = $urandom_range(0, 400);
            metric.tlast = $urandom_range(0, 15) == 0;
            detect.tready = $urandom_range(0, 3) != 0;
            @(posedge clk);
            #1;
        end
        metric.tvalid = 1'b0;
        detect.tready = 1'b1;
        send(32'd0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        build_expected(thr);
        compare_recs("rand");
    endtask

    initial begin
        metric.tvalid = 1'b0;
        metric.tlast = 1'b0;
        metric.tdata = '0;
        detect.tready = 1'b1;

        // ramp
        do_reset();
        threshold = 32'd100;
        send(10, 0); send(50, 0); send(120, 0); send(300, 0); send(200, 0);
        check("ramp_pre_valid", detect.tvalid, 0);
        send(90, 0);
        check("ramp_latency", detect.tvalid, 1);
        send(80, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_rec(3, 0, 300);
        compare_recs("ramp");

        // ties keep the earliest; hold-off swallows the 500s, then re-arm
        do_reset();
        repeat (4) send(150, 0);
        send(500, 0); send(500, 0);
        send(500, 0); send(1, 0); send(1, 0); send(1, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_rec(0, 0, 150);
        expect_rec(6, 0, 500);
        compare_recs("tie");

        // early tlast, next burst immediately armed
        do_reset();
        repeat (7) send(10, 0);
        send(200, 0);
        send(250, 1);
        send(300, 0); send(1, 0); send(1, 0); send(1, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_rec(8, 1, 250);
        expect_rec(9, 0, 300);
        compare_recs("tlast");

        // back-pressure
        do_reset();
        detect.tready = 1'b0;
        send(120, 0); send(130, 0); send(140, 0); send(150, 0);
        metric.tdata = 7;
        metric.tlast = 1'b0;
        metric.tvalid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", metric.tready, 0);
            check("bp_valid", detect.tvalid, 1);
            check("bp_data", detect.tdata, 3);
        end
        @(posedge clk);
        #1 detect.tready = 1'b1;
        @(posedge clk);
        #1 detect.tready = 1'b0;
        metric.tvalid = 1'b0;
        check("bp_released", got_idx.size(), 1);
        detect.tready = 1'b1;
        send(1, 0); send(1, 0); send(200, 0); send(1, 0); send(1, 0); send(1, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_rec(3, 0, 150);
        expect_rec(6, 0, 200);
        compare_recs("bp");

        // async reset mid-SEARCH
        do_reset();
        repeat (4) send(10, 0);
        send(200, 0); send(210, 0);
        #2 reset = 1'b1;
        #1;
        check("rst_search_valid", detect.tvalid, 0);
        check("rst_search_ready", metric.tready, 1);
        flush_logs();
        @(posedge clk);
        #3 reset = 1'b0;
        send(300, 0); send(1, 0); send(1, 0); send(1, 0);
        repeat (3) @(posedge clk);
        #1;
        expect_rec(0, 0, 300);
        compare_recs("rst_search");

        // async reset mid-REPORT drops the record
        send(1, 0); send(1, 0);
        detect.tready = 1'b0;
        send(400, 0); send(1, 0); send(1, 0); send(1, 0);
        check("rst_report_pre", detect.tvalid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_report_valid", detect.tvalid, 0);
        flush_logs();
        @(posedge clk);
        #3 reset = 1'b0;
        detect.tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_report_dropped", got_idx.size(), 0);

        // random run, then a clear that lands mid-SEARCH together with a beat, then a second random run
        do_reset();
        random_run(600, 250);
        send(500, 0);
        send(1, 0);
        metric.tdata = 999;
        metric.tlast = 1'b0;
        metric.tvalid = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        metric.tvalid = 1'b0;
        flush_logs();
        check("clear_valid", detect.tvalid, 0);
        random_run(600, 150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
